// File: rtl/sfx_sequencer.sv
// Priority-arbitrated sound-effect sequencer: walks note dividers from an external
// synchronous ROM and turns each note into a volume-scaled square-wave sample.
module sfx_sequencer #(
  parameter int NUM_FX   = 4,
  parameter int NOTES    = 16,
  parameter int BEAT_DIV = 12500000,
  parameter int DIV_W    = 22,
  parameter int AMP_W    = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_FX-1:0]                         trig,
  input  logic                                      mute,
  input  logic [2:0]                                volume,
  output logic [$clog2(NUM_FX)+$clog2(NOTES)-1:0]   rom_addr,
  input  logic [DIV_W-1:0]                          rom_div,
  output logic                                      busy,
  output logic [$clog2(NUM_FX)-1:0]                 cur_fx,
  output logic                                      done,
  output logic [AMP_W-1:0]                          audio
);

  localparam int FX_W   = $clog2(NUM_FX);
  localparam int IDX_W  = $clog2(NOTES);
  localparam int BEAT_W = $clog2(BEAT_DIV);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  note_idx;
  logic [BEAT_W-1:0] beat_cnt;
  logic [DIV_W-1:0]  note_div;
  logic [DIV_W-1:0]  tone_cnt;
  logic              phase;
  logic [FX_W-1:0]   winner;
  logic              start, load, advance, finish;

  // phase 0 is the high half of the square wave, phase 1 sits at the base level
  function automatic logic [AMP_W-1:0] amp_level(input logic [2:0] vol, input logic ph);
    logic [AMP_W-1:0] base;
    base = AMP_W'(1) << (AMP_W - 3);
    if (ph) return base;
    return base + (AMP_W'(vol) << (AMP_W - 6));
  endfunction

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_FX; i++)
      if (trig[i]) winner = FX_W'(i);
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: ;
      FETCH: state_d = LOAD;
      LOAD: begin
        if (rom_div == '0) begin
          state_d = IDLE;
          finish  = 1'b1;
        end else begin
          load    = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (beat_cnt == BEAT_W'(BEAT_DIV - 1)) begin
          if (note_idx == IDX_W'(NOTES - 1)) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A start or an equal/higher-priority preemption overrides everything else.
    if (|trig && (state == IDLE || winner >= cur_fx)) begin
      start   = 1'b1;
      load    = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      note_idx <= '0;
      beat_cnt <= '0;
      note_div <= '0;
      tone_cnt <= '0;
      phase    <= 1'b0;
      rom_addr <= '0;
      cur_fx   <= '0;
      done     <= 1'b0;
      audio    <= '0;
    end else begin
      state <= state_d;
      done  <= finish;
      if (start) begin
        cur_fx   <= winner;
        note_idx <= '0;
        rom_addr <= {winner, IDX_W'(0)};
      end else if (advance) begin
        note_idx <= note_idx + 1'b1;
        rom_addr <= {cur_fx, note_idx + IDX_W'(1)};
      end
      if (load) begin
        note_div <= rom_div;
        beat_cnt <= '0;
        tone_cnt <= '0;
        phase    <= 1'b0;
      end else if (state == PLAY) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (note_div >= DIV_W'(2)) begin
          if (tone_cnt == note_div) begin
            tone_cnt <= '0;
            phase    <= ~phase;
          end else begin
            tone_cnt <= tone_cnt + 1'b1;
          end
        end
      end
      if (mute || state != PLAY || note_div == DIV_W'(1))
        audio <= '0;
      else
        audio <= amp_level(volume, phase);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer: a per-cycle vector table for a basic effect,
// then hand-timed sequences for full-length play, preemption, mute/volume and reset.
module tb_sfx_sequencer;

  localparam int NUM_FX   = 2;
  localparam int NOTES    = 4;
  localparam int BEAT_DIV = 8;
  localparam int DIV_W    = 22;
  localparam int AMP_W    = 16;

  localparam logic [15:0] HI5 = 16'h3400;
  localparam logic [15:0] BASE = 16'h2000;
  localparam logic [15:0] HI7 = 16'h3C00;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       trig;
  logic             mute;
  logic [2:0]       volume;
  logic [2:0]       rom_addr;
  logic [DIV_W-1:0] rom_div;
  logic             busy;
  logic [0:0]       cur_fx;
  logic             done;
  logic [15:0]      audio;

  logic [DIV_W-1:0] rom [8];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  trig;
    logic        mute;
    logic [2:0]  vol;
    logic        busy;
    logic        fx;
    logic [2:0]  addr;
    logic        done;
    logic [15:0] audio;
  } vec_t;

  vec_t vecs[$];

  sfx_sequencer #(
    .NUM_FX(NUM_FX), .NOTES(NOTES), .BEAT_DIV(BEAT_DIV), .DIV_W(DIV_W), .AMP_W(AMP_W)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .mute(mute), .volume(volume),
    .rom_addr(rom_addr), .rom_div(rom_div), .busy(busy), .cur_fx(cur_fx),
    .done(done), .audio(audio)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_div <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] t, input logic m, input logic [2:0] v,
                     input logic b, input logic f, input logic [2:0] a, input logic d,
                     input logic [15:0] au);
    vec_t x;
    x.rst = r; x.trig = t; x.mute = m; x.vol = v;
    x.busy = b; x.fx = f; x.addr = a; x.done = d; x.audio = au;
    vecs.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int dones;
    rst = 1'b1; trig = '0; mute = 1'b0; volume = 3'd5;
    rom[0] = 22'd3; rom[1] = 22'd3; rom[2] = 22'd0; rom[3] = 22'd0;
    rom[4] = 22'd2; rom[5] = 22'd1; rom[6] = 22'd2; rom[7] = 22'd5;

    // Basic play of fx0 = {3,3,0}: two notes, terminator at note 2.
    add(1, 2'b00, 0, 5,  0, 0, 0, 0, 16'h0);
    add(1, 2'b01, 0, 5,  0, 0, 0, 0, 16'h0);
    add(0, 2'b01, 0, 5,  1, 0, 0, 0, 16'h0);
    add(0, 2'b00, 0, 5,  1, 0, 0, 0, 16'h0);
    add(0, 2'b00, 0, 5,  1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) add(0, 2'b00, 0, 5, 1, 0, 0, 0, HI5);
    for (int i = 0; i < 3; i++) add(0, 2'b00, 0, 5, 1, 0, 0, 0, BASE);
    add(0, 2'b00, 0, 5,  1, 0, 1, 0, BASE);
    add(0, 2'b00, 0, 5,  1, 0, 1, 0, 16'h0);
    add(0, 2'b00, 0, 5,  1, 0, 1, 0, 16'h0);
    for (int i = 0; i < 4; i++) add(0, 2'b00, 0, 5, 1, 0, 1, 0, HI5);
    for (int i = 0; i < 3; i++) add(0, 2'b00, 0, 5, 1, 0, 1, 0, BASE);
    add(0, 2'b00, 0, 5,  1, 0, 2, 0, BASE);
    add(0, 2'b00, 0, 5,  1, 0, 2, 0, 16'h0);
    add(0, 2'b00, 0, 5,  0, 0, 2, 1, 16'h0);
    add(0, 2'b00, 0, 5,  0, 0, 2, 0, 16'h0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; trig = vecs[i].trig; mute = vecs[i].mute; volume = vecs[i].vol;
      step();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_fx", i), 32'(cur_fx), 32'(vecs[i].fx));
      chk($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_audio", i), 32'(audio), 32'(vecs[i].audio));
    end
    rst = 1'b0; trig = '0; mute = 1'b0; volume = 3'd5;

    // Full-length fx1 = {2,1,2,5}: no terminator, done after 4 notes at t+41.
    dones = 0;
    for (int k = 0; k <= 41; k++) begin
      trig = (k == 0) ? 2'b10 : 2'b00;
      step();
      s = k + 1;
      dones += int'(done);
      if (s == 1) begin chk("a_fx", 32'(cur_fx), 1); chk("a_addr0", 32'(rom_addr), 4); end
      if (s == 5) chk("a_n0_hi", 32'(audio), 32'(HI5));
      if (s == 8) chk("a_n0_lo", 32'(audio), 32'(BASE));
      if (s == 15) begin chk("a_rest", 32'(audio), 0); chk("a_rest_busy", 32'(busy), 1); end
      if (s == 33) chk("a_addr3", 32'(rom_addr), 7);
      if (s == 38) chk("a_n3_hi", 32'(audio), 32'(HI5));
      if (s == 40) begin chk("a_n3_lo", 32'(audio), 32'(BASE)); chk("a_done_early", 32'(done), 0); end
      if (s == 41) begin chk("a_done", 32'(done), 1); chk("a_busy_end", 32'(busy), 0); end
      if (s == 42) chk("a_audio_end", 32'(audio), 0);
    end
    chk("a_done_count", 32'(dones), 1);

    // Preemption by fx1, ignored lower trigger, then same-fx retrigger in note 2.
    dones = 0;
    for (int k = 0; k <= 71; k++) begin
      trig = (k == 0) ? 2'b01 : (k == 5) ? 2'b10 : (k == 10) ? 2'b01 : (k == 30) ? 2'b10 : 2'b00;
      step();
      s = k + 1;
      dones += int'(done);
      if (s == 6) begin
        chk("b_pre_fx", 32'(cur_fx), 1); chk("b_pre_addr", 32'(rom_addr), 4);
        chk("b_pre_busy", 32'(busy), 1); chk("b_pre_done", 32'(done), 0);
      end
      if (s == 11) begin chk("b_ign_fx", 32'(cur_fx), 1); chk("b_ign_addr", 32'(rom_addr), 4); end
      if (s == 16) chk("b_addr1", 32'(rom_addr), 5);
      if (s == 29) chk("b_addr2", 32'(rom_addr), 6);
      if (s == 31) begin chk("b_retrig_addr", 32'(rom_addr), 4); chk("b_retrig_fx", 32'(cur_fx), 1); end
      if (s == 70) begin chk("b_busy_late", 32'(busy), 1); chk("b_done_late", 32'(done), 0); end
      if (s == 71) begin chk("b_done", 32'(done), 1); chk("b_busy_end", 32'(busy), 0); end
    end
    chk("b_done_count", 32'(dones), 1);

    // Volume change without phase disturbance, mute mid-note with unchanged timing.
    volume = 3'd0;
    for (int k = 0; k <= 23; k++) begin
      trig   = (k == 0) ? 2'b01 : 2'b00;
      volume = (k >= 5) ? 3'd7 : 3'd0;
      mute   = (k >= 15 && k <= 17);
      step();
      s = k + 1;
      if (s == 5) chk("c_vol0_hi", 32'(audio), 32'(BASE));
      if (s == 6) chk("c_vol7_hi", 32'(audio), 32'(HI7));
      if (s == 7) chk("c_vol7_hold", 32'(audio), 32'(HI7));
      if (s == 8) chk("c_vol7_lo", 32'(audio), 32'(BASE));
      if (s == 14) chk("c_n1_hi", 32'(audio), 32'(HI7));
      if (s == 16) begin chk("c_mute", 32'(audio), 0); chk("c_mute_busy", 32'(busy), 1); end
      if (s == 17) chk("c_mute_hold", 32'(audio), 0);
      if (s == 19) chk("c_unmute", 32'(audio), 32'(BASE));
      if (s == 21) chk("c_addr2", 32'(rom_addr), 2);
      if (s == 23) begin chk("c_done", 32'(done), 1); chk("c_busy_end", 32'(busy), 0); end
    end
    mute = 1'b0; volume = 3'd5;

    // Simultaneous triggers, reset mid-PLAY together with a trigger, then restart.
    dones = 0;
    for (int k = 0; k <= 13; k++) begin
      trig = (k == 0) ? 2'b11 : (k == 5 || k == 9) ? 2'b01 : 2'b00;
      rst  = (k == 5);
      step();
      s = k + 1;
      dones += int'(done);
      if (s == 1) begin chk("d_both_fx", 32'(cur_fx), 1); chk("d_both_addr", 32'(rom_addr), 4); end
      if (s == 6) begin
        chk("d_rst_busy", 32'(busy), 0); chk("d_rst_fx", 32'(cur_fx), 0);
        chk("d_rst_addr", 32'(rom_addr), 0); chk("d_rst_done", 32'(done), 0);
        chk("d_rst_audio", 32'(audio), 0);
      end
      if (s == 8) chk("d_idle_busy", 32'(busy), 0);
      if (s == 10) begin
        chk("d_restart_busy", 32'(busy), 1); chk("d_restart_fx", 32'(cur_fx), 0);
        chk("d_restart_addr", 32'(rom_addr), 0);
      end
      if (s == 12) chk("d_restart_quiet", 32'(audio), 0);
      if (s == 13) chk("d_restart_hi", 32'(audio), 32'(HI5));
    end
    chk("d_done_count", 32'(dones), 0);
    rst = 1'b0; trig = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Parametrised, priority-arbitrated sound-effect sequencer for the game audio path. It plays a note sequence for each of NUM_FX effects. Note dividers come from an external synchronous ROM, and the block produces a square-wave sample with volume control. It sits between the game-event logic (jump, score, crash triggers) and `speaker_control`. It replaces the fixed two-effect beat counter, the hard-wired tone table and the note generator with one block.

## Interface
- NUM_FX, 4, number of effects; trigger bit index is also priority (higher index wins); power of 2, ≥2
- NOTES, 16, note slots per effect; power of 2, ≥2
- BEAT_DIV, 12500000, clk cycles per note slot; ≥4
- DIV_W, 22, width of note half-period divider
- AMP_W, 16, sample width; ≥8
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- trig  in  NUM_FX  one-cycle effect request pulses
- mute  in  1  forces audio to 0; sequencing continues
- volume  in  3  amplitude select 0..7
- rom_addr  out  log2(NUM_FX)+log2(NOTES)  {fx, note_idx}, registered
- rom_div  in  DIV_W  ROM data; valid the cycle after rom_addr changes. 0 = end of effect, 1 = rest, ≥2 = half-period in clk cycles
- busy  out  1  state ≠ IDLE
- cur_fx  out  log2(NUM_FX)  effect being played
- done  out  1  one-cycle pulse on natural completion
- audio  out  AMP_W  sample for both channels

## Operation
- States: IDLE, FETCH, LOAD, PLAY.
- Arbitration: the winner is the highest set bit of trig.
  - In IDLE, any trig starts the winner.
  - In FETCH/LOAD/PLAY, a winner with index ≥ cur_fx preempts: it restarts at note 0, including a retrigger of the same fx.
  - A lower-index winner is ignored.
  - Preemption overrides every other transition in that cycle.
- Start/preempt: cur_fx←winner, note_idx←0, rom_addr←{winner,0}, state←FETCH.
- FETCH → LOAD unconditionally.
- LOAD:
  - If rom_div==0: state←IDLE, done pulses next cycle.
  - Otherwise: note_div←rom_div, beat_cnt←0, tone_cnt←0, phase←0, state←PLAY.
- PLAY:
  - beat_cnt increments each cycle.
  - At beat_cnt==BEAT_DIV-1, if note_idx==NOTES-1: state←IDLE and done pulses. Otherwise: note_idx+1, rom_addr updated, state←FETCH.
- Tone, in PLAY with note_div≥2:
  - When tone_cnt==note_div: tone_cnt←0 and phase toggles.
  - Otherwise tone_cnt increments.
  - Counter width is DIV_W.
- Amplitude: base = 2^(AMP_W-3), hi = base + volume·2^(AMP_W-6). For AMP_W=16: base 0x2000, vol 7 → 0x3C00.
- audio is registered:
  - 0 if mute, state≠PLAY, or note_div==1.
  - Otherwise phase==0 → hi, phase==1 → base.
- done is never asserted on preemption or reset.
- rst: state IDLE, all counters 0, note_div 0, phase 0. Outputs rom_addr 0, busy 0, cur_fx 0, done 0, audio 0. Reset has priority over trig in the same cycle. Reset mid-effect aborts with no done pulse.

## Timing
- Trigger sampled in cycle t from IDLE:
  - t+1: FETCH, busy=1, rom_addr={fx,0}.
  - t+2: LOAD, rom_div consumed.
  - t+3: PLAY.
  - t+4: first nonzero audio, because audio is registered.
- Each note occupies BEAT_DIV PLAY cycles plus 2 fetch cycles; audio is 0 during the fetch gap.
- A square half-period lasts note_div+1 cycles.
- done is high for exactly the one cycle after the IDLE transition; busy is 0 in that same cycle.
- volume and mute take effect on the next audio register update. Changing volume does not reset phase.

## Test plan
- **Basic play** (NUM_FX=2, NOTES=4, BEAT_DIV=8; ROM fx0 = {3,3,0,x}): trig=01 at t → rom_addr 0,1,2 are issued. audio alternates 0x2000+vol·0x400 / 0x2000 every 4 cycles during each PLAY. Encountering 0 at note 2 → done pulses once, busy falls, audio=0.
- **Full-length effect** (fx1 = {2,1,2,5}, no terminator): all 4 notes play and the rest note gives audio=0 for 8 cycles. done pulses after the 4th note at cycle t+3+4·8+3·2.
- **Priority and preemption**: fx0 playing, trig=10 mid-PLAY → the next cycle is FETCH with cur_fx=1 and rom_addr={1,0}, and no done. trig=01 while fx1 plays → ignored. Simultaneous trig=11 from IDLE → cur_fx=1.
- **Same-fx retrigger**: trig=10 during fx1 note 2 → note_idx restarts at 0 and total duration is extended.
- **Mute/volume**: mute=1 mid-note → audio=0 next cycle while busy stays 1 and the sequence timing is unchanged. volume 0→7 → high level changes 0x2000→0x3C00 without phase disturbance.
- **Reset mid-operation**: rst high for 1 cycle during PLAY together with trig=01 → all outputs 0 the following cycle, no done, IDLE. A subsequent trig starts normally at note 0.
